// File: rtl/sys_bus_if.sv
// Bundled handshake and shared-bus signals for sys_bus_arbiter.
// slave = arbiter side; master = requesters plus the downstream bus slave.
interface sys_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_ack;
  logic              m0_err;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_ack;
  logic              m1_err;
  logic [DATA_W-1:0] m1_rdata;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_ack, m0_err, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_ack, m1_err, m1_rdata,
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_ack, m0_err, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_ack, m1_err, m1_rdata,
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/sys_bus_arbiter.sv
// Two-master / one-slave system bus arbiter, round-robin or fixed priority.
// Optional BUSY watchdog with error completion is enabled by defining ARB_TIMEOUT_EN.
module sys_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  sys_bus_if.slave bus,
  output logic     arb_owner,
  output logic     arb_busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(32'hDEAD_BEEF);

  state_t state_reg, state_next;
  logic   owner_reg, owner_next;
  logic   last_owner_reg, last_owner_next;

  logic [1:0]        req_vec, we_vec, gnt_vec, ack_vec, err_vec;
  logic [ADDR_W-1:0] addr_vec  [2];
  logic [DATA_W-1:0] wdata_vec [2];
  logic [DATA_W-1:0] rdata_vec [2];

  logic busy, owner_req, done_ok, timeout_hit;

  assign req_vec      = {bus.m1_req, bus.m0_req};
  assign we_vec       = {bus.m1_we, bus.m0_we};
  assign addr_vec[0]  = bus.m0_addr;
  assign addr_vec[1]  = bus.m1_addr;
  assign wdata_vec[0] = bus.m0_wdata;
  assign wdata_vec[1] = bus.m1_wdata;

  assign busy      = (state_reg == BUSY);
  assign owner_req = req_vec[owner_reg];
  // bus_ack only counts while the owner is still driving its request
  assign done_ok   = busy && owner_req && bus.bus_ack;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] to_cnt_reg, to_cnt_next;

  assign timeout_hit = busy && owner_req && !bus.bus_ack
                       && (to_cnt_reg == CNT_W'(TIMEOUT - 1));

  always_comb begin
    to_cnt_next = to_cnt_reg;
    if (!busy)
      to_cnt_next = '0;
    else if (!bus.bus_ack)
      to_cnt_next = to_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt_reg <= '0;
    else
      to_cnt_reg <= to_cnt_next;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          state_next = BUSY;
          if (&req_vec)
            owner_next = (FIXED_PRIO != 0) ? 1'b0 : ~last_owner_reg;
          else
            owner_next = req_vec[1];
        end
      end
      BUSY: begin
        // a dropped request aborts silently and leaves fairness history alone
        if (!owner_req) begin
          state_next = IDLE;
        end else if (done_ok || timeout_hit) begin
          state_next      = IDLE;
          last_owner_next = owner_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign gnt_vec[gi]   = busy && ((gi == 0) ? !owner_reg : owner_reg);
      assign ack_vec[gi]   = gnt_vec[gi] && (done_ok || timeout_hit);
      assign err_vec[gi]   = gnt_vec[gi] && timeout_hit;
      assign rdata_vec[gi] = !ack_vec[gi] ? '0 :
                             (timeout_hit ? ERR_WORD : bus.bus_rdata);
    end
  endgenerate

  assign bus.bus_req   = busy && owner_req && !timeout_hit;
  assign bus.bus_we    = busy && we_vec[owner_reg];
  assign bus.bus_addr  = busy ? addr_vec[owner_reg]  : '0;
  assign bus.bus_wdata = busy ? wdata_vec[owner_reg] : '0;

  assign bus.m0_gnt   = gnt_vec[0];
  assign bus.m0_ack   = ack_vec[0];
  assign bus.m0_err   = err_vec[0];
  assign bus.m0_rdata = rdata_vec[0];
  assign bus.m1_gnt   = gnt_vec[1];
  assign bus.m1_ack   = ack_vec[1];
  assign bus.m1_err   = err_vec[1];
  assign bus.m1_rdata = rdata_vec[1];

  assign arb_owner = owner_reg;
  assign arb_busy  = busy;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Bench for sys_bus_arbiter: a round-robin and a fixed-priority instance share one stimulus.
// Directed scenarios plus a randomized run against a transaction-level reference model.
module tb_sys_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m_req   [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic        s_ack;
  logic [31:0] s_rdata;

  int total = 0;
  int bad   = 0;

  sys_bus_if #(.ADDR_W(AW), .DATA_W(DW)) bif_rr ();
  sys_bus_if #(.ADDR_W(AW), .DATA_W(DW)) bif_fp ();

  logic rr_owner, rr_busy, fp_owner, fp_busy;

  sys_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0), .TIMEOUT(TO)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(bif_rr), .arb_owner(rr_owner), .arb_busy(rr_busy));
  sys_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1), .TIMEOUT(TO)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bif_fp), .arb_owner(fp_owner), .arb_busy(fp_busy));

  assign bif_rr.m0_req = m_req[0];   assign bif_fp.m0_req = m_req[0];
  assign bif_rr.m0_we = m_we[0];     assign bif_fp.m0_we = m_we[0];
  assign bif_rr.m0_addr = m_addr[0]; assign bif_fp.m0_addr = m_addr[0];
  assign bif_rr.m0_wdata = m_wdata[0]; assign bif_fp.m0_wdata = m_wdata[0];
  assign bif_rr.m1_req = m_req[1];   assign bif_fp.m1_req = m_req[1];
  assign bif_rr.m1_we = m_we[1];     assign bif_fp.m1_we = m_we[1];
  assign bif_rr.m1_addr = m_addr[1]; assign bif_fp.m1_addr = m_addr[1];
  assign bif_rr.m1_wdata = m_wdata[1]; assign bif_fp.m1_wdata = m_wdata[1];
  assign bif_rr.bus_ack = s_ack;     assign bif_fp.bus_ack = s_ack;
  assign bif_rr.bus_rdata = s_rdata; assign bif_fp.bus_rdata = s_rdata;

  logic [137:0] act_rr, act_fp;
  assign act_rr = {bif_rr.m0_gnt, bif_rr.m1_gnt, bif_rr.m0_ack, bif_rr.m1_ack,
                   bif_rr.m0_err, bif_rr.m1_err, bif_rr.bus_req, bif_rr.bus_we,
                   rr_busy, rr_owner, bif_rr.m0_rdata, bif_rr.m1_rdata,
                   bif_rr.bus_addr, bif_rr.bus_wdata};
  assign act_fp = {bif_fp.m0_gnt, bif_fp.m1_gnt, bif_fp.m0_ack, bif_fp.m1_ack,
                   bif_fp.m0_err, bif_fp.m1_err, bif_fp.bus_req, bif_fp.bus_we,
                   fp_busy, fp_owner, bif_fp.m0_rdata, bif_fp.m1_rdata,
                   bif_fp.bus_addr, bif_fp.bus_wdata};

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      m_req[m] = 1'b0; m_we[m] = 1'b0; m_addr[m] = '0; m_wdata[m] = '0;
    end
    s_ack = 1'b0; s_rdata = '0;
  endtask

  task automatic pulse_reset();
    step();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    step();
    #1;
    total++;
    if (act_rr !== '0) begin
      bad++; $display("FAIL reset_rr: got %h expected 0", act_rr);
    end
    total++;
    if (act_fp !== '0) begin
      bad++; $display("FAIL reset_fp: got %h expected 0", act_fp);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    step();
    m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h0000_1000;
    #1;
    total++;
    if ({rr_busy, bif_rr.m0_gnt} !== 2'b00) begin
      bad++; $display("FAIL read_idle: got busy/gnt=%b expected 00", {rr_busy, bif_rr.m0_gnt});
    end
    for (int w = 0; w < 3; w++) begin
      step();
      s_ack = (w == 2);
      s_rdata = (w == 2) ? 32'h1234_5678 : 32'hA5A5_A5A5;
      #1;
      total++;
      if ({bif_rr.m0_gnt, bif_rr.m1_gnt, bif_rr.m0_ack, bif_rr.m1_ack, bif_rr.bus_req,
           bif_rr.bus_we, bif_rr.bus_addr} !== {1'b1, 1'b0, (w == 2), 1'b0, 1'b1, 1'b0, 32'h0000_1000}) begin
        bad++; $display("FAIL read_wait%0d: got gnt/ack/req=%b%b%b%b%b addr=%h expected %b addr=00001000",
                        w, bif_rr.m0_gnt, bif_rr.m1_gnt, bif_rr.m0_ack, bif_rr.m1_ack,
                        bif_rr.bus_req, bif_rr.bus_addr, {1'b1, 1'b0, (w == 2), 1'b0, 1'b1});
      end
    end
    total++;
    if ({bif_rr.m0_rdata, bif_rr.m1_rdata} !== {32'h1234_5678, 32'h0}) begin
      bad++; $display("FAIL read_data: got m0=%h m1=%h expected 12345678 00000000",
                      bif_rr.m0_rdata, bif_rr.m1_rdata);
    end
    $display("txn single_read m0 addr=%h rdata=%h", bif_rr.bus_addr, bif_rr.m0_rdata);
    step();
    m_req[0] = 1'b0; s_ack = 1'b0;
    #1;
    total++;
    if ({rr_busy, bif_rr.m0_gnt} !== 2'b00) begin
      bad++; $display("FAIL read_release: got busy/gnt=%b expected 00", {rr_busy, bif_rr.m0_gnt});
    end
  endtask

  task automatic test_contention();
    logic [1:0] eg;
    pulse_reset();
    for (int t = 0; t < 8; t++) begin
      step();
      m_req[0] = 1'b1; m_req[1] = 1'b1; s_ack = 1'b1; s_rdata = 32'h0000_0100 + t;
      #1;
      if (t % 2 == 0) begin
        total++;
        if ({rr_busy, fp_busy} !== 2'b00) begin
          bad++; $display("FAIL contend_idle%0d: got busy rr/fp=%b expected 00", t, {rr_busy, fp_busy});
        end
      end else begin
        eg = ((t / 2) % 2 == 0) ? 2'b10 : 2'b01;
        total++;
        if ({bif_rr.m0_gnt, bif_rr.m1_gnt, bif_rr.m0_ack, bif_rr.m1_ack, rr_owner}
            !== {eg, eg, 1'((t / 2) % 2)}) begin
          bad++; $display("FAIL rr_turn%0d: got gnt=%b%b ack=%b%b owner=%b expected gnt/ack=%b owner=%0d",
                          t / 2, bif_rr.m0_gnt, bif_rr.m1_gnt, bif_rr.m0_ack, bif_rr.m1_ack,
                          rr_owner, eg, (t / 2) % 2);
        end
        total++;
        if ({bif_fp.m0_gnt, bif_fp.m1_gnt, bif_fp.m0_ack, fp_owner} !== 4'b1010) begin
          bad++; $display("FAIL fp_turn%0d: got gnt=%b%b ack0=%b owner=%b expected 1010",
                          t / 2, bif_fp.m0_gnt, bif_fp.m1_gnt, bif_fp.m0_ack, fp_owner);
        end
        $display("txn contend rr_owner=%0d fp_owner=%0d", rr_owner, fp_owner);
      end
    end
    step();
    m_req[0] = 1'b0;
    #1;
    step();
    #1;
    total++;
    if ({bif_fp.m0_gnt, bif_fp.m1_gnt, bif_fp.m1_ack, fp_owner} !== 4'b0111) begin
      bad++; $display("FAIL fp_m1_after_drop: got gnt=%b%b ack1=%b owner=%b expected 0111",
                      bif_fp.m0_gnt, bif_fp.m1_gnt, bif_fp.m1_ack, fp_owner);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_write();
    step();
    m_req[1] = 1'b1; m_we[1] = 1'b1; m_addr[1] = 32'h2000_0004; m_wdata[1] = 32'h0000_00FF;
    for (int w = 0; w < 3; w++) begin
      if (w > 0) step();
      s_ack = (w == 2);
      #1;
      if (w > 0) begin
        total++;
        if ({bif_rr.m1_gnt, bif_rr.bus_req, bif_rr.bus_we, bif_rr.m1_ack, bif_rr.m0_ack,
             bif_rr.bus_addr, bif_rr.bus_wdata} !== {3'b111, (w == 2), 1'b0, 32'h2000_0004, 32'h0000_00FF}) begin
          bad++; $display("FAIL write_%0d: got gnt/req/we/ack1/ack0=%b%b%b%b%b addr=%h wdata=%h expected %b%b 20000004 000000ff",
                          w, bif_rr.m1_gnt, bif_rr.bus_req, bif_rr.bus_we, bif_rr.m1_ack,
                          bif_rr.m0_ack, bif_rr.bus_addr, bif_rr.bus_wdata, 3'b111, (w == 2));
        end
      end
    end
    $display("txn write m1 addr=%h wdata=%h", bif_rr.bus_addr, bif_rr.bus_wdata);
    step();
    clear_inputs();
  endtask

  task automatic test_abort();
    step();
    m_req[0] = 1'b1; m_addr[0] = 32'h0000_3000;
    step();
    #1;
    total++;
    if (bif_rr.m0_gnt !== 1'b1) begin
      bad++; $display("FAIL abort_gnt: got %b expected 1", bif_rr.m0_gnt);
    end
    step();
    m_req[0] = 1'b0; s_ack = 1'b1;
    #1;
    total++;
    if ({bif_rr.bus_req, bif_rr.m0_ack, bif_rr.m1_ack} !== 3'b000) begin
      bad++; $display("FAIL abort_drop: got req/ack0/ack1=%b expected 000",
                      {bif_rr.bus_req, bif_rr.m0_ack, bif_rr.m1_ack});
    end
    step();
    s_ack = 1'b0;
    #1;
    total++;
    if ({rr_busy, bif_rr.m0_gnt} !== 2'b00) begin
      bad++; $display("FAIL abort_idle: got busy/gnt=%b expected 00", {rr_busy, bif_rr.m0_gnt});
    end
    // last owner was m1 (write); an aborted m0 must not count, so m0 wins the tie
    m_req[0] = 1'b1; m_req[1] = 1'b1;
    step();
    s_ack = 1'b1;
    #1;
    total++;
    if ({rr_owner, bif_rr.m0_gnt, bif_rr.m0_ack} !== 3'b011) begin
      bad++; $display("FAIL abort_history: got owner/gnt0/ack0=%b expected 011",
                      {rr_owner, bif_rr.m0_gnt, bif_rr.m0_ack});
    end
    step();
    clear_inputs();
  endtask

  task automatic test_async_reset();
    step();
    m_req[0] = 1'b1; m_addr[0] = 32'h0000_4000;
    step();
    #1;
    total++;
    if (rr_busy !== 1'b1) begin
      bad++; $display("FAIL areset_pre: got busy=%b expected 1", rr_busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({act_rr, act_fp} !== '0) begin
      bad++; $display("FAIL areset_mid: got rr=%h fp=%h expected 0", act_rr, act_fp);
    end
    m_req[0] = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    bit ack_seen;
    step();
    clear_inputs();
    m_req[0] = 1'b1; m_addr[0] = 32'h0000_5000;
    if (TMO_EN) begin
      for (int i = 1; i <= TO; i++) begin
        step();
        #1;
        total++;
        if ({bif_rr.m0_gnt, bif_rr.m0_ack, bif_rr.m0_err, bif_rr.bus_req} !== ((i < TO) ? 4'b1001 : 4'b1110)) begin
          bad++; $display("FAIL timeout_cyc%0d: got gnt/ack/err/req=%b expected %b", i,
                          {bif_rr.m0_gnt, bif_rr.m0_ack, bif_rr.m0_err, bif_rr.bus_req},
                          (i < TO) ? 4'b1001 : 4'b1110);
        end
      end
      total++;
      if (bif_rr.m0_rdata !== 32'hDEAD_BEEF) begin
        bad++; $display("FAIL timeout_rdata: got %h expected deadbeef", bif_rr.m0_rdata);
      end
      $display("txn timeout m0 err=%b rdata=%h", bif_rr.m0_err, bif_rr.m0_rdata);
    end else begin
      ack_seen = 1'b0;
      for (int i = 1; i <= 110; i++) begin
        step();
        #1;
        if (bif_rr.m0_ack || bif_rr.m0_err) ack_seen = 1'b1;
      end
      total++;
      if ({bif_rr.m0_gnt, rr_busy, ack_seen} !== 3'b110) begin
        bad++; $display("FAIL hang_110: got gnt/busy/ack_seen=%b expected 110",
                        {bif_rr.m0_gnt, rr_busy, ack_seen});
      end
      $display("txn hang m0 still granted after 110 cycles");
    end
    step();
    m_req[0] = 1'b0;
    step();
    #1;
    total++;
    if (rr_busy !== 1'b0) begin
      bad++; $display("FAIL timeout_idle: got busy=%b expected 0", rr_busy);
    end
  endtask

  task automatic test_random();
    bit          mb [2];
    bit          mw [2];
    bit          ml [2];
    int          mc [2];
    int          ack_div;
    int          who;
    bit          rq, done, tmo, ok;
    logic        g [2], a [2], e [2];
    logic [31:0] rd [2];
    logic        breq, bwe;
    logic [31:0] ba, bw;
    logic [137:0] exp_v, act_v;
    int          ntxn;
    pulse_reset();
    for (int d = 0; d < 2; d++) begin
      mb[d] = 1'b0; mw[d] = 1'b0; ml[d] = 1'b1; mc[d] = 0;
    end
    ack_div = 2;
    ntxn = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (cyc % 200 == 0) ack_div = ($urandom % 2 == 0) ? 2 : 24;
      for (int m = 0; m < 2; m++) begin
        if ($urandom % 6 == 0) m_req[m] = ~m_req[m];
        m_we[m] = 1'($urandom); m_addr[m] = $urandom; m_wdata[m] = $urandom;
      end
      s_ack = ($urandom % ack_div) == 0;
      s_rdata = $urandom;
      #1;
      for (int d = 0; d < 2; d++) begin
        g = '{1'b0, 1'b0}; a = '{1'b0, 1'b0}; e = '{1'b0, 1'b0}; rd = '{32'h0, 32'h0};
        breq = 1'b0; bwe = 1'b0; ba = '0; bw = '0;
        exp_v = '0;
        if (mb[d]) begin
          who  = int'(mw[d]);
          rq   = m_req[who];
          done = rq && s_ack;
          tmo  = TMO_EN && rq && !s_ack && (mc[d] == TO - 1);
          g[who] = 1'b1;
          breq = rq && !tmo;
          bwe = m_we[who]; ba = m_addr[who]; bw = m_wdata[who];
          if (done || tmo) begin
            a[who] = 1'b1; e[who] = tmo; rd[who] = done ? s_rdata : 32'hDEAD_BEEF;
          end
          exp_v = {g[0], g[1], a[0], a[1], e[0], e[1], breq, bwe, 1'b1, mw[d], rd[0], rd[1], ba, bw};
          if (!rq) begin
            mb[d] = 1'b0;
          end else if (done || tmo) begin
            mb[d] = 1'b0; ml[d] = mw[d];
            if (d == 0) ntxn++;
          end else begin
            mc[d]++;
          end
        end else begin
          exp_v = {9'b0, mw[d], 128'b0};
          if (m_req[0] || m_req[1]) begin
            mb[d] = 1'b1; mc[d] = 0;
            if (m_req[0] && m_req[1]) mw[d] = (d == 1) ? 1'b0 : ~ml[d];
            else mw[d] = m_req[1];
          end
        end
        act_v = (d == 0) ? act_rr : act_fp;
        total++;
        ok = (act_v === exp_v);
        if (!ok) begin
          bad++; $display("FAIL random_%s cyc=%0d: got %h expected %h", (d == 0) ? "rr" : "fp", cyc, act_v, exp_v);
        end
      end
    end
    $display("txn random run completed %0d rr transactions", ntxn);
    step();
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_abort();
    test_async_reset();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
